// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised asynchronous-serial transmitter.
// Frame = start bit, DATA_BITS data bits, optional parity bit, 1 or 2 stop bits.
// A one-word holding register lets a new word wait while the current frame
// shifts out, so frames can run back-to-back with no idle bit between them.
//
// Ports:
//   clk    in   system clock, all logic on posedge
//   rst_n  in   asynchronous active-low reset
//   data   in   word to send, sampled when valid && ready
//   valid  in   producer has a word on data
//   ready  out  holding register empty, a word can be accepted
//   tx     out  serial line, idle high, driven from a flop
//   busy   out  frame in progress or word held
module uart_tx_frame #(
  parameter int unsigned CLK_DIV   = 167,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Elaboration-time parameter checks
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("uart_tx_frame: CLK_DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (MSB_FIRST > 1) begin : g_bad_msb_first
    $error("uart_tx_frame: MSB_FIRST must be 0 or 1");
  end

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 tx_d, ready_d, busy_d;

  logic                 bit_tick;
  logic                 accept;
  logic                 load;
  logic                 first_bit;
  logic [DATA_BITS-1:0] shifted;

  // Bit-period counter tick and the next data bit off the shifter
  always_comb begin
    bit_tick  = (cnt_q == CNT_W'(CLK_DIV - 1));
    accept    = valid && !hold_full_q;
    first_bit = (MSB_FIRST != 0) ? shift_q[DATA_BITS-1] : shift_q[0];
    shifted   = (MSB_FIRST != 0) ? {shift_q[DATA_BITS-2:0], 1'b0}
                                 : {1'b0, shift_q[DATA_BITS-1:1]};
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    stop_d      = stop_q;
    par_d       = par_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_d        = tx;
    load        = 1'b0;
    // Counter parked at 0 in IDLE so the first start bit is full length
    cnt_d       = (state_q == S_IDLE || bit_tick) ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (hold_full_q) load = 1'b1;
      end
      S_START: begin
        if (bit_tick) begin
          state_d = S_DATA;
          tx_d    = first_bit;
          shift_d = shifted;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
              stop_d  = 1'b0;
            end
          end else begin
            tx_d    = first_bit;
            shift_d = shifted;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_tick) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          stop_d  = 1'b0;
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          if (stop_q == 1'(STOP_BITS - 1)) begin
            // A held word starts immediately, with no idle bit in between
            if (hold_full_q) load = 1'b1;
            else             state_d = S_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Parity is computed once from the held word, at load time
    if (load) begin
      shift_d     = hold_q;
      par_d       = (PARITY == 2) ? ^hold_q : ~^hold_q;
      state_d     = S_START;
      tx_d        = 1'b0;
      hold_full_d = 1'b0;
    end

    if (accept) begin
      hold_d      = data;
      hold_full_d = 1'b1;
    end

    ready_d = !hold_full_d;
    busy_d  = (state_d != S_IDLE) || hold_full_d;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      stop_q      <= 1'b0;
      par_q       <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx          <= 1'b1;
      ready       <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      stop_q      <= stop_d;
      par_q       <= par_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx          <= tx_d;
      ready       <= ready_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: four instances cover 8N1, 8E1, 8O1 and
// 7O2 LSB-first at CLK_DIV=4; sel picks which one is driven and observed.
module tb_uart_tx_frame;

  localparam int unsigned DIV = 4;

  logic       clk;
  logic       rst_n;
  logic [8:0] data;
  logic       valid;
  logic [1:0] sel;
  logic [3:0] valid_w, rdy_w, tx_w, busy_w;
  logic       tx_m, rdy_m, busy_m;

  int n_tests = 0;
  int n_fail  = 0;

  assign valid_w = valid ? (4'b0001 << sel) : 4'b0000;
  assign tx_m    = tx_w[sel];
  assign rdy_m   = rdy_w[sel];
  assign busy_m  = busy_w[sel];

  uart_tx_frame #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .MSB_FIRST(1))
    u_8n1 (.clk(clk), .rst_n(rst_n), .data(data[7:0]), .valid(valid_w[0]),
           .ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));

  uart_tx_frame #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .MSB_FIRST(1))
    u_8e1 (.clk(clk), .rst_n(rst_n), .data(data[7:0]), .valid(valid_w[1]),
           .ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));

  uart_tx_frame #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .MSB_FIRST(1))
    u_8o1 (.clk(clk), .rst_n(rst_n), .data(data[7:0]), .valid(valid_w[2]),
           .ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));

  uart_tx_frame #(.CLK_DIV(DIV), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .MSB_FIRST(0))
    u_7o2 (.clk(clk), .rst_n(rst_n), .data(data[6:0]), .valid(valid_w[3]),
           .ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a word, wait (bounded) for ready, release valid after the accepting edge
  task automatic push(input logic [8:0] w);
    int n;
    n = 0;
    @(negedge clk);
    data  = w;
    valid = 1'b1;
    while (!rdy_m && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", 32'(rdy_m), 32'd1);
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  // Called right after the accepting edge; bits[n-1] is the first bit on the line.
  // ready is expected low for samples lo_from..lo_to (sample 0 = first start-bit cycle).
  task automatic check_frame(input logic [31:0] bits, input int n,
                             input int lo_from, input int lo_to);
    int s;
    @(negedge clk);
    check("pre_tx", 32'(tx_m), 32'd1);
    check("pre_ready", 32'(rdy_m), 32'd0);
    check("pre_busy", 32'(busy_m), 32'd1);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < int'(DIV); c++) begin
        @(negedge clk);
        s = k * int'(DIV) + c;
        check($sformatf("tx_bit%0d_c%0d", k, c), 32'(tx_m), 32'(bits[n-1-k]));
        check($sformatf("busy_bit%0d", k), 32'(busy_m), 32'd1);
        check($sformatf("ready_s%0d", s), 32'(rdy_m),
              (s >= lo_from && s <= lo_to) ? 32'd0 : 32'd1);
      end
    end
    @(negedge clk);
    check("post_tx", 32'(tx_m), 32'd1);
    check("post_busy", 32'(busy_m), 32'd0);
    check("post_ready", 32'(rdy_m), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic bad;
    rst_n = 1'b0;
    valid = 1'b0;
    data  = '0;
    sel   = 2'd0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      check($sformatf("rst_tx%0d", i), 32'(tx_m), 32'd1);
      check($sformatf("rst_ready%0d", i), 32'(rdy_m), 32'd1);
      check($sformatf("rst_busy%0d", i), 32'(busy_m), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 MSB-first 0xA5
    sel = 2'd0;
    push(9'h0A5);
    check_frame(32'b0101001011, 10, 1, 0);

    // 8E1 and 8O1 0xA5: parity 0 then 1
    sel = 2'd1;
    push(9'h0A5);
    check_frame(32'b01010010101, 11, 1, 0);
    sel = 2'd2;
    push(9'h0A5);
    check_frame(32'b01010010111, 11, 1, 0);

    // Back-to-back 0x00 then 0xFF, contiguous frames
    sel = 2'd0;
    push(9'h000);
    fork
      push(9'h0FF);
      check_frame(32'b0000000001_0111111111, 20, 1, 39);
    join

    // 7O2 LSB-first 7'h41
    sel = 2'd3;
    push(9'h041);
    check_frame(32'b01000001111, 11, 1, 0);

    // Backpressure: changing data with valid high while a word is held
    sel = 2'd0;
    push(9'h03C);
    fork
      begin
        push(9'h0C3);
        for (int k = 0; k < 38; k++) begin
          @(negedge clk);
          data  = 9'(k * 53 + 7);
          valid = 1'b1;
        end
        @(negedge clk);
        valid = 1'b0;
      end
      check_frame(32'b0001111001_0110000111, 20, 1, 39);
    join

    // Reset mid-frame during data bit 3 with a word held
    sel = 2'd0;
    push(9'h000);
    push(9'h0FF);
    repeat (16) @(negedge clk);
    check("mid_tx", 32'(tx_m), 32'd0);
    check("mid_ready", 32'(rdy_m), 32'd0);
    check("mid_busy", 32'(busy_m), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tx", 32'(tx_m), 32'd1);
    check("arst_ready", 32'(rdy_m), 32'd1);
    check("arst_busy", 32'(busy_m), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (tx_m !== 1'b1 || busy_m !== 1'b0 || rdy_m !== 1'b1) bad = 1'b1;
    end
    check("idle_after_rst", 32'(bad), 32'd0);

    // Fresh word after reset goes out normally
    push(9'h0A5);
    check_frame(32'b0101001011, 10, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised asynchronous-serial transmitter. Serialises one word per frame onto a single tx line: start bit, DATA_BITS data bits, optional parity bit, then 1 or 2 stop bits. Words enter through a valid/ready handshake into a one-word holding register, so frames can run back-to-back with no idle gap. Sits between any byte producer and the board-level serial pin.

Parameters:
CLK_DIV, 167, clk cycles per bit; legal range >= 2; bit counter width $clog2(CLK_DIV)
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
MSB_FIRST, 1, 1 = data[DATA_BITS-1] sent first; 0 = data[0] sent first

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
data  in  DATA_BITS  word to send; sampled when valid && ready
valid  in  1  producer has a word on data
ready  out  1  holding register empty; a word can be accepted
tx  out  1  serial line; idle high; driven from a flop
busy  out  1  frame in progress or word held

Behaviour:
- Reset (async assert, sync-to-clk deassert handled externally): tx=1, ready=1, busy=0. FSM goes to IDLE, holding register is empty, bit counter = 0. Any frame in flight is abandoned with no partial stop bit, and any held word is discarded.
- Handshake: a transfer occurs on a posedge where valid && ready. data is copied into hold, and hold_full is set. ready = !hold_full. A valid held while ready=0 has no effect, and the producer must hold data stable.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE, hold_full=1 at posedge: load the shifter from hold and clear hold_full. Go to START, set tx=0, clear the bit counter.
  - Latency: word accepted on edge E0; START begins on edge E1; ready=1 again after E1.
  - Load and accept on the same edge: hold_full stays 1 with the new word.
- Bit timing: the bit counter counts 0..CLK_DIV-1, and bit_tick = (count == CLK_DIV-1). Every bit, including each stop bit, lasts exactly CLK_DIV cycles. The counter is held at 0 in IDLE, so the first start bit is never short.
- START: on bit_tick, go to DATA with tx = first data bit.
- DATA: shift per MSB_FIRST. On the bit_tick ending bit DATA_BITS, go to PARITY if PARITY!=0, else to STOP.
- PARITY: tx = ^word for even parity, ~^word for odd parity, so the data bits plus the parity bit have an even or odd count of ones respectively. On bit_tick, go to STOP.
- STOP: tx=1 for STOP_BITS bit periods. On the final bit_tick:
  - hold_full=1: load from hold and go directly to START (tx=0 on the next cycle, no idle bit).
  - otherwise: go to IDLE.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLK_DIV cycles.
- busy = (state != IDLE) || hold_full.
- The data input is never read by the FSM directly. Only the internal shifter is used, so changing data after acceptance does not corrupt the frame.
- Illegal parameter values are rejected by an elaboration-time check ($error in an initial/generate block).

Test Plan:
1. CLK_DIV=4, 8N1, MSB_FIRST=1. Send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1. Each level lasts 4 cycles and the frame is 40 cycles. START begins 1 cycle after acceptance, and tx=1 after the frame.
2. Same config with PARITY=2, then PARITY=1, sending 0xA5 -> parity bit 0 (even) and 1 (odd), each appearing after the 8 data bits. Frame length 44 cycles.
3. Back-to-back: present 0x00, then 0xFF, with valid held high. The second word is accepted during frame 1 and ready stays low until frame 2 loads. The frames are contiguous, total 80 cycles, with no extra high bit between the stop bit and the second start bit. busy=1 throughout and 0 afterwards.
4. DATA_BITS=7, MSB_FIRST=0, PARITY=1, STOP_BITS=2, CLK_DIV=4. Send 7'h41 -> tx = 0,1,0,0,0,0,0,1,1,1,1, i.e. start, LSB-first data, parity 1, two stop bits. Frame 44 cycles.
5. Reset mid-frame: assert rst_n=0 during data bit 3 with a word held -> tx=1, ready=1, busy=0 immediately (asynchronous). After release, tx stays 1 and nothing is sent until a new valid.
6. Backpressure: valid high with a changing data value while ready=0 -> no acceptance. The transmitted frame matches the word accepted at the handshake edge.
